gate_seq: RTL

//  Requester side of the label_ctl fetch/store protocol; drives evaluation of one netlist pass.
//  - Walks the gate list from index 0 to num_gates-1.
//  - Per gate: issues fetch-1 and fetch-2 strobes, hands the combined label to the crypto core,

---
 rtl/gc_pkg.sv | 36 +++
 rtl/gate_seq.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gc_pkg.sv
// Shared constants for the garbled-circuit gate sequencer: widths, gate types,
// descriptor field offsets and the sequencer state encoding.
package gc_pkg;

    localparam int unsigned GC_ID_W    = 13;
    localparam int unsigned GC_LABEL_W = 128;
    localparam int unsigned GC_CNT_W   = 13;

    // Gate type encodings shared with label_ctl and the crypto core
    localparam logic [1:0] GATE_AND = 2'd0;
    localparam logic [1:0] GATE_XOR = 2'd1;
    localparam logic [1:0] GATE_BUF = 2'd2;

    // Descriptor layout: {type, in1, in2, out}
    localparam int unsigned DESC_OUT_LSB  = 0;
    localparam int unsigned DESC_IN2_LSB  = GC_ID_W;
    localparam int unsigned DESC_IN1_LSB  = 2 * GC_ID_W;
    localparam int unsigned DESC_TYPE_LSB = 3 * GC_ID_W;
    localparam int unsigned DESC_W        = 3 * GC_ID_W + 2;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_RD   = 4'd1,
        ST_RDW  = 4'd2,
        ST_F1   = 4'd3,
        ST_F1W  = 4'd4,
        ST_F2   = 4'd5,
        ST_F2W  = 4'd6,
        ST_CORE = 4'd7,
        ST_RES  = 4'd8,
        ST_ST   = 4'd9,
        ST_STW  = 4'd10,
        ST_NEXT = 4'd11
    } gs_state_e;

endpackage

// File: rtl/gate_seq.sv
// gate_seq: walks a netlist pass gate by gate. For each gate it reads the
// descriptor, fetches the input label(s) through label_ctl, hands the label to
// the crypto core, and stores the core's result under the gate's output wire.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   start, num_gates                 pass request (num_gates sampled on start)
//   busy, done, err                  pass status; err is sticky until next start
//   gate_addr, gate_rd, gate_rd_valid, gate_desc      descriptor memory
//   wire_id_read, id_1_strobe, id_2_strobe, gate_type,
//   wire_id_write, store_strobe, label_wr,
//   lc_done, lc_label, lc_point                       label_ctl
//   core_valid, core_ready, core_label, core_point, core_type,
//   res_valid, res_label                              crypto core
module gate_seq
    import gc_pkg::*;
#(
    parameter int unsigned ID_W    = GC_ID_W,
    parameter int unsigned LABEL_W = GC_LABEL_W,
    parameter int unsigned CNT_W   = GC_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [CNT_W-1:0]     num_gates,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [CNT_W-1:0]     gate_addr,
    output logic                 gate_rd,
    input  logic                 gate_rd_valid,
    input  logic [3*ID_W+1:0]    gate_desc,
    output logic [ID_W-1:0]      wire_id_read,
    output logic                 id_1_strobe,
    output logic                 id_2_strobe,
    output logic [1:0]           gate_type,
    output logic [ID_W-1:0]      wire_id_write,
    output logic                 store_strobe,
    output logic [LABEL_W-1:0]   label_wr,
    input  logic                 lc_done,
    input  logic [LABEL_W-1:0]   lc_label,
    input  logic [1:0]           lc_point,
    output logic                 core_valid,
    input  logic                 core_ready,
    output logic [LABEL_W-1:0]   core_label,
    output logic [1:0]           core_point,
    output logic [1:0]           core_type,
    input  logic                 res_valid,
    input  logic [LABEL_W-1:0]   res_label
);

    localparam int unsigned OUT_LSB  = 0;
    localparam int unsigned IN2_LSB  = ID_W;
    localparam int unsigned IN1_LSB  = 2 * ID_W;
    localparam int unsigned TYPE_LSB = 3 * ID_W;

    gs_state_e        state_q, state_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [ID_W-1:0]  in2_q, in2_d;
    logic [ID_W-1:0]  out_q, out_d;
    logic [1:0]       type_q, type_d;

    logic               busy_d, done_d, err_d, gate_rd_d;
    logic [CNT_W-1:0]   gate_addr_d;
    logic [ID_W-1:0]    wire_id_read_d, wire_id_write_d;
    logic               id_1_strobe_d, id_2_strobe_d, store_strobe_d;
    logic [1:0]         gate_type_d;
    logic [LABEL_W-1:0] label_wr_d;
    logic               core_valid_d;
    logic [LABEL_W-1:0] core_label_d;
    logic [1:0]         core_point_d, core_type_d;

    logic [CNT_W-1:0]   idx_inc;

    assign idx_inc = idx_q + CNT_W'(1);

    // Next-state and next-output logic
    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        num_d           = num_q;
        in2_d           = in2_q;
        out_d           = out_q;
        type_d          = type_q;
        busy_d          = busy;
        done_d          = 1'b0;
        err_d           = err;
        gate_addr_d     = gate_addr;
        gate_rd_d       = 1'b0;
        wire_id_read_d  = wire_id_read;
        id_1_strobe_d   = 1'b0;
        id_2_strobe_d   = 1'b0;
        gate_type_d     = gate_type;
        wire_id_write_d = wire_id_write;
        store_strobe_d  = 1'b0;
        label_wr_d      = label_wr;
        core_valid_d    = core_valid;
        core_label_d    = core_label;
        core_point_d    = core_point;
        core_type_d     = core_type;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    err_d = 1'b0;
                    num_d = num_gates;
                    idx_d = '0;
                    if (num_gates == '0) begin
                        done_d = 1'b1;
                    end else begin
                        busy_d      = 1'b1;
                        gate_addr_d = '0;
                        gate_rd_d   = 1'b1;
                        state_d     = ST_RD;
                    end
                end
            end
            ST_RD: state_d = ST_RDW;
            ST_RDW: begin
                if (gate_rd_valid) begin
                    in2_d          = gate_desc[IN2_LSB +: ID_W];
                    out_d          = gate_desc[OUT_LSB +: ID_W];
                    type_d         = gate_desc[TYPE_LSB +: 2];
                    wire_id_read_d = gate_desc[IN1_LSB +: ID_W];
                    gate_type_d    = gate_desc[TYPE_LSB +: 2];
                    id_1_strobe_d  = 1'b1;
                    state_d        = ST_F1;
                end
            end
            ST_F1: state_d = ST_F1W;
            ST_F1W: begin
                if (lc_done) begin
                    if (type_q == GATE_BUF) begin
                        // Single-input gate: hand the first label straight to the core
                        core_label_d = lc_label;
                        core_point_d = 2'd0;
                        core_type_d  = type_q;
                        core_valid_d = 1'b1;
                        state_d      = ST_CORE;
                    end else begin
                        wire_id_read_d = in2_q;
                        id_2_strobe_d  = 1'b1;
                        state_d        = ST_F2;
                    end
                end
            end
            ST_F2: state_d = ST_F2W;
            ST_F2W: begin
                if (lc_done) begin
                    core_label_d = lc_label;
                    core_point_d = lc_point;
                    core_type_d  = type_q;
                    core_valid_d = 1'b1;
                    state_d      = ST_CORE;
                end
            end
            ST_CORE: begin
                if (core_ready) begin
                    core_valid_d = 1'b0;
                    state_d      = ST_RES;
                end
            end
            ST_RES: begin
                if (res_valid) begin
                    label_wr_d      = res_label;
                    wire_id_write_d = out_q;
                    store_strobe_d  = 1'b1;
                    state_d         = ST_ST;
                end
            end
            ST_ST: state_d = ST_STW;
            ST_STW: begin
                if (lc_done) begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (idx_inc == num_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    idx_d       = idx_inc;
                    gate_addr_d = idx_inc;
                    gate_rd_d   = 1'b1;
                    state_d     = ST_RD;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Unexpected handshakes flag an error; their data is never used
        if (lc_done && !(state_q inside {ST_F1W, ST_F2W, ST_STW})) begin
            err_d = 1'b1;
        end
        if (res_valid && (state_q != ST_RES)) begin
            err_d = 1'b1;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            num_q         <= '0;
            in2_q         <= '0;
            out_q         <= '0;
            type_q        <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            gate_addr     <= '0;
            gate_rd       <= 1'b0;
            wire_id_read  <= '0;
            id_1_strobe   <= 1'b0;
            id_2_strobe   <= 1'b0;
            gate_type     <= '0;
            wire_id_write <= '0;
            store_strobe  <= 1'b0;
            label_wr      <= '0;
            core_valid    <= 1'b0;
            core_label    <= '0;
            core_point    <= '0;
            core_type     <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            num_q         <= num_d;
            in2_q         <= in2_d;
            out_q         <= out_d;
            type_q        <= type_d;
            busy          <= busy_d;
            done          <= done_d;
            err           <= err_d;
            gate_addr     <= gate_addr_d;
            gate_rd       <= gate_rd_d;
            wire_id_read  <= wire_id_read_d;
            id_1_strobe   <= id_1_strobe_d;
            id_2_strobe   <= id_2_strobe_d;
            gate_type     <= gate_type_d;
            wire_id_write <= wire_id_write_d;
            store_strobe  <= store_strobe_d;
            label_wr      <= label_wr_d;
            core_valid    <= core_valid_d;
            core_label    <= core_label_d;
            core_point    <= core_point_d;
            core_type     <= core_type_d;
        end
    end

endmodule
